// File: rtl/relatorio_pkg.sv
// Shared definitions for the serial report formatter.
//   estado_t  : FSM state codes, also exported on db_estado
//   ASC_*     : ASCII anchors used to build hex digits and the class field
//   MSG_LEN   : number of characters in one report
package relatorio_pkg;

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    TRANSMITE = 4'd2,
    ESPERA    = 4'd3,
    PROXIMO   = 4'd4,
    FIM       = 4'd5,
    ERRO      = 4'd6
  } estado_t;

  localparam logic [7:0] ASC_0 = 8'h30;
  localparam logic [7:0] ASC_A = 8'h41;
  localparam logic [7:0] ASC_D = 8'h44;

  localparam int         MSG_LEN  = 6;
  localparam logic [2:0] IDX_LAST = 3'(MSG_LEN - 1);

endpackage

// File: rtl/relatorio_serial_tx_contador.sv
// contador_m: modulo-M up counter with synchronous clear.
//   clock  : rising-edge clock
//   zera_s : synchronous clear, highest priority
//   conta  : count enable
//   fim    : high while the count equals M-1
module contador_m #(
  parameter int M = 1000000,
  parameter int N = 20
) (
  input  logic clock,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  localparam logic [N-1:0] MAX = N'(M - 1);
  localparam logic [N-1:0] UM  = N'(1);

  logic [N-1:0] q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (zera_s)     q <= '0;
    else if (conta) q <= (q == MAX) ? '0 : q + UM;
  end

  assign fim = (q == MAX);

endmodule

// File: rtl/relatorio_serial_tx_hex.sv
// hex_para_ascii: converts one nibble to its uppercase ASCII hex digit.
//   nibble : 4-bit value 0..15
//   ascii  : '0'..'9' or 'A'..'F'
module hex_para_ascii
  import relatorio_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = ASC_0 + {4'b0000, nibble};
    else                ascii = ASC_A + ({4'b0000, nibble} - 8'd10);
  end

endmodule

// File: rtl/relatorio_serial_tx.sv
// relatorio_serial_tx: snapshots distance + classification on a start request
// and sends the 6-character report "HHH,C#" through the partida/pronto
// handshake of tx_serial_8N1, with a stall timeout.
//   clock, zera          : clock and synchronous active-high reset
//   enviar               : start request (honoured in INICIAL, FIM, ERRO)
//   distancia            : 12-bit averaged distance (three hex digits)
//   classificacao        : 3-bit class code
//   descartar            : measurement discarded ('D' instead of class digit)
//   tx_pronto            : character done, from the transmitter
//   tx_partida, tx_dados : start pulse and byte to the transmitter
//   ocupado              : report in progress
//   fim_envio            : one-cycle pulse after the terminator is acknowledged
//   erro_timeout         : transmitter stalled; held until the next enviar
//   db_estado            : current state code
module relatorio_serial_tx
  import relatorio_pkg::*;
#(
  parameter int         TIMEOUT   = 1000000,
  parameter int         TIMEOUT_W = 20,
  parameter logic [7:0] SEP       = 8'h2C,
  parameter logic [7:0] TERM      = 8'h23
) (
  input  logic        clock,
  input  logic        zera,
  input  logic        enviar,
  input  logic [11:0] distancia,
  input  logic [2:0]  classificacao,
  input  logic        descartar,
  input  logic        tx_pronto,
  output logic        tx_partida,
  output logic [7:0]  tx_dados,
  output logic        ocupado,
  output logic        fim_envio,
  output logic        erro_timeout,
  output logic [3:0]  db_estado
);

  estado_t     estado, prox_estado;
  logic [2:0]  idx;
  logic [11:0] dist_q;
  logic [2:0]  class_q;
  logic        desc_q;
  logic [7:0]  dados_q;
  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic [7:0]  byte_atual;
  logic        timeout_fim;

  // State register
  always_ff @(posedge clock) begin
    if (zera) estado <= INICIAL;
    else      estado <= prox_estado;
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    prox_estado = estado;
    unique case (estado)
      INICIAL:   if (enviar) prox_estado = PREPARA;
      PREPARA:   prox_estado = TRANSMITE;
      TRANSMITE: prox_estado = ESPERA;
      ESPERA: begin
        if (tx_pronto)        prox_estado = PROXIMO;
        else if (timeout_fim) prox_estado = ERRO;
      end
      PROXIMO:   prox_estado = (idx == IDX_LAST) ? FIM : TRANSMITE;
      FIM:       prox_estado = enviar ? PREPARA : INICIAL;
      ERRO:      if (enviar) prox_estado = PREPARA;
      default:   prox_estado = INICIAL;
    endcase
  end

  // Output logic
  always_comb begin
    tx_partida   = (estado == TRANSMITE);
    ocupado      = (estado == PREPARA) || (estado == TRANSMITE) ||
                   (estado == ESPERA)  || (estado == PROXIMO);
    fim_envio    = (estado == FIM);
    erro_timeout = (estado == ERRO);
    db_estado    = estado;
    // Live byte while the character is on the wire, last byte otherwise.
    tx_dados     = ((estado == TRANSMITE) || (estado == ESPERA)) ? byte_atual
                                                                 : dados_q;
  end

  // Snapshot, byte index and held output byte.
  // NOTE: the snapshot registers are plain flops, cleared on reset so the
  // outputs are fully defined from the first cycle after zera.
  always_ff @(posedge clock) begin
    if (zera) begin
      idx     <= '0;
      dist_q  <= '0;
      class_q <= '0;
      desc_q  <= 1'b0;
      dados_q <= '0;
    end else begin
      if (estado == PREPARA) begin
        dist_q  <= distancia;
        class_q <= classificacao;
        desc_q  <= descartar;
        idx     <= '0;
      end
      if ((estado == PROXIMO) && (idx != IDX_LAST)) idx <= idx + 3'd1;
      if ((estado == TRANSMITE) || (estado == ESPERA)) dados_q <= byte_atual;
    end
  end

  // One shared converter; the nibble is chosen by the byte index.
  always_comb begin
    nibble = dist_q[3:0];
    case (idx)
      3'd0:    nibble = dist_q[11:8];
      3'd1:    nibble = dist_q[7:4];
      default: nibble = dist_q[3:0];
    endcase
  end

  hex_para_ascii u_hex (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  always_comb begin
    byte_atual = TERM;
    case (idx)
      3'd0, 3'd1, 3'd2: byte_atual = hex_char;
      3'd3:             byte_atual = SEP;
      3'd4:             byte_atual = desc_q ? ASC_D : (ASC_0 + {5'b00000, class_q});
      default:          byte_atual = TERM;
    endcase
  end

  // Stall timer: cleared at each character start, counts only while waiting.
  contador_m #(
    .M (TIMEOUT),
    .N (TIMEOUT_W)
  ) u_timeout (
    .clock  (clock),
    .zera_s (zera | (estado == TRANSMITE)),
    .conta  (estado == ESPERA),
    .fim    (timeout_fim)
  );

endmodule

// File: doc/relatorio_serial_tx.md
Name: relatorio_serial_tx

Overview:
- Downstream stage of the level-monitor datapath. On a start pulse it snapshots the averaged distance and its classification, formats them as a fixed 6-character ASCII report, and feeds the report byte-by-byte to tx_serial_8N1 through its partida/pronto handshake.
- Replaces the free-running character counter and mux in front of the serial transmitter.
- Adds proper hex digits, a classification field and a stall timeout.

Parameters:
- TIMEOUT, 1000000: clock cycles allowed in ESPERA for tx_pronto before flagging an error.
- TIMEOUT_W, 20: width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT.
- SEP, 8'h2C: separator character (',').
- TERM, 8'h23: terminator character ('#').

Ports:
- clock, in, 1: single system clock, rising edge.
- zera, in, 1: synchronous active-high reset.
- enviar, in, 1: start request; sampled only in INICIAL, FIM or ERRO.
- distancia, in, 12: averaged distance, 3 nibbles.
- classificacao, in, 3: classifier code, 0..7.
- descartar, in, 1: classifier discarded the measurement.
- tx_pronto, in, 1: end-of-character indication from tx_serial_8N1.
- tx_partida, out, 1: one-cycle start pulse to tx_serial_8N1.
- tx_dados, out, 8: ASCII byte to transmit; held stable from tx_partida until tx_pronto.
- ocupado, out, 1: high from PREPARA through PROXIMO.
- fim_envio, out, 1: one-cycle pulse after the terminator is acknowledged.
- erro_timeout, out, 1: sticky error flag.
- db_estado, out, 4: current state code.

Behaviour:
- Reset: zera=1 at an edge forces state INICIAL and clears the byte index, timeout counter and snapshot registers. Every output is 0 after reset, db_estado=0.
- zera has priority over every other input in every state, including mid-message. No further tx_partida is issued after a reset.
- States and codes: INICIAL=0, PREPARA=1, TRANSMITE=2, ESPERA=3, PROXIMO=4, FIM=5, ERRO=6.
- INICIAL: enviar=1 -> PREPARA.
- PREPARA: latch distancia, classificacao and descartar into the snapshot; idx=0 -> TRANSMITE.
- TRANSMITE: tx_partida=1 for exactly one cycle; clear the timeout counter -> ESPERA.
- ESPERA:
  - tx_pronto=1 -> PROXIMO.
  - Otherwise increment the timeout counter; when it reaches TIMEOUT-1 -> ERRO.
  - tx_pronto is ignored in TRANSMITE, so a stale level from the previous character is never consumed.
- PROXIMO: idx==5 -> FIM; otherwise idx+1 -> TRANSMITE.
- FIM: fim_envio=1 for one cycle.
  - enviar=1 -> PREPARA (back-to-back reports allowed).
  - Otherwise -> INICIAL.
- ERRO: erro_timeout=1 and ocupado=0.
  - enviar=1 clears erro_timeout and goes to PREPARA.
  - Otherwise stays in ERRO.
- Latency: enviar sampled at edge t gives PREPARA after t, and tx_partida is high in the cycle after edge t+1.
- Input stability: enviar in PREPARA through PROXIMO is ignored, with no queuing. Input changes after PREPARA do not affect the report in flight.
- Byte map (idx -> tx_dados):
  - 0: hex(d[11:8]).
  - 1: hex(d[7:4]).
  - 2: hex(d[3:0]).
  - 3: SEP.
  - 4: class character.
  - 5: TERM.
- hex(n): n<10 gives 8'h30+n; n>=10 gives 8'h41+(n-10) (uppercase). All arithmetic is 8-bit with no overflow.
- Class character: descartar=1 gives 8'h44 ('D'); otherwise 8'h30+classificacao.
- tx_dados outside TRANSMITE/ESPERA holds its last value; it is 0 after reset.

Decomposition:
- Package relatorio_pkg holds:
  - state codes 0..6;
  - ASCII constants ASC_0=8'h30, ASC_A=8'h41, ASC_D=8'h44;
  - MSG_LEN=6.
- Sub-module hex_para_ascii: combinational, 4-bit nibble in, 8-bit ASCII out. It is instantiated three times, or once with a nibble mux selected by idx.
- The timeout counter is an existing contador_m instance (M=TIMEOUT, N=TIMEOUT_W):
  - zera_s driven by zera OR TRANSMITE;
  - conta driven by ESPERA;
  - fim used as the timeout condition.

Test Plan:
- Nominal report: distancia=12'h1A3, classificacao=2, descartar=0, enviar pulse; bench model returns tx_pronto 10 cycles after each tx_partida.
  - Required: exactly 6 tx_partida pulses carrying 31,41,33,2C,32,23.
  - Then one fim_envio pulse; ocupado drops to 0 in the same cycle as FIM.
- Discard and extremes: distancia=12'hF09, classificacao=7, descartar=1.
  - Required bytes: 46,30,39,2C,44,23.
  - Repeat with descartar=0: 5th byte is 37.
- Snapshot and busy: change distancia to 12'h000 and pulse enviar during byte 2.
  - Required: report still 31,41,33,...; no extra report, only 6 partida pulses total.
- Timeout: with TIMEOUT=50, tx_pronto held 0.
  - Required: erro_timeout rises 50±1 cycles after the first tx_partida; no second partida.
  - A subsequent enviar clears the flag and restarts at byte 0.
- Reset mid-operation: assert zera for 1 cycle while in ESPERA on byte 3.
  - Required: next cycle all outputs are 0 and db_estado=0; no partida until a new enviar.
- Back-to-back: enviar high in the FIM cycle.
  - Required: second report starts with tx_partida 2 cycles later; the two messages are 12 bytes total.
